// File: rtl/rv_decode_exec_if.sv
// Bus between fetch/register file and the decode/execute block.
// The master side supplies instruction, PC and register operands; the slave side returns decoded control and ALU results.
interface rv_decode_exec_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [31:0]       insn_i;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] rs1data_i;
  logic [DWIDTH-1:0] rs2data_i;

  logic [AWIDTH-1:0] pc_o;
  logic [31:0]       insn_o;
  logic [6:0]        opcode_o;
  logic [4:0]        rd_o;
  logic [2:0]        funct3_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [6:0]        funct7_o;
  logic [4:0]        shamt_o;
  logic [31:0]       imm_o;
  logic              pcsel_o;
  logic              immsel_o;
  logic              regwren_o;
  logic              rs1sel_o;
  logic              rs2sel_o;
  logic              memren_o;
  logic              memwren_o;
  logic [1:0]        wbsel_o;
  logic [3:0]        alusel_o;
  logic [DWIDTH-1:0] res_o;
  logic              brtaken_o;

  modport master (
    output insn_i, pc_i, rs1data_i, rs2data_i,
    input  pc_o, insn_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, shamt_o,
    input  imm_o, pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o,
    input  wbsel_o, alusel_o, res_o, brtaken_o
  );

  modport slave (
    input  insn_i, pc_i, rs1data_i, rs2data_i,
    output pc_o, insn_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, shamt_o,
    output imm_o, pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o,
    output wbsel_o, alusel_o, res_o, brtaken_o
  );
endinterface

// File: rtl/rv_decode_exec.sv
// RV32I decode/control/execute: registers instruction and PC, then decodes and executes combinationally.
// One instruction per cycle, no stall; outputs follow the registered state with zero added latency.
module rv_decode_exec #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  rv_decode_exec_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  logic [AWIDTH-1:0] pc_q;
  logic [31:0]       insn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      insn_q <= '0;
    end else begin
      pc_q   <= bus.pc_i;
      insn_q <= bus.insn_i;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = insn_q[6:0];
  assign funct3 = insn_q[14:12];
  assign funct7 = insn_q[31:25];

  assign bus.pc_o     = pc_q;
  assign bus.insn_o   = insn_q;
  assign bus.opcode_o = opcode;
  assign bus.rd_o     = insn_q[11:7];
  assign bus.funct3_o = funct3;
  assign bus.rs1_o    = insn_q[19:15];
  assign bus.rs2_o    = insn_q[24:20];
  assign bus.funct7_o = funct7;
  assign bus.shamt_o  = insn_q[24:20];

  logic [31:0] imm;

  always_comb begin
    imm = '0;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{insn_q[31]}}, insn_q[31:20]};
      OP_STORE:                 imm = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
      OP_BRANCH:                imm = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25],
                                       insn_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {insn_q[31:12], 12'b0};
      OP_JAL:                   imm = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20],
                                       insn_q[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

  assign bus.imm_o = imm;

  logic    pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren, known;
  logic [1:0] wbsel;
  alu_op_e alusel;
  alu_op_e arith_op;

  // Register and immediate arithmetic share the funct3 map; only the SUB/SRA override differs.
  always_comb begin
    arith_op = ALU_ADD;
    unique case (funct3)
      3'b000: arith_op = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      3'b111: arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    pcsel   = 1'b0;
    immsel  = 1'b0;
    regwren = 1'b0;
    rs1sel  = 1'b0;
    rs2sel  = 1'b0;
    memren  = 1'b0;
    memwren = 1'b0;
    wbsel   = 2'd0;
    alusel  = ALU_ADD;
    known   = 1'b1;
    unique case (opcode)
      OP_R:      begin regwren = 1'b1; alusel = arith_op; end
      OP_IMM:    begin regwren = 1'b1; immsel = 1'b1; rs2sel = 1'b1; alusel = arith_op; end
      OP_LOAD:   begin regwren = 1'b1; memren = 1'b1; immsel = 1'b1; rs2sel = 1'b1; wbsel = 2'd1; end
      OP_STORE:  begin memwren = 1'b1; immsel = 1'b1; rs2sel = 1'b1; end
      OP_BRANCH: begin pcsel = 1'b1; immsel = 1'b1; rs1sel = 1'b1; rs2sel = 1'b1; end
      OP_JAL:    begin
        pcsel = 1'b1; regwren = 1'b1; immsel = 1'b1; rs1sel = 1'b1; rs2sel = 1'b1; wbsel = 2'd2;
      end
      OP_JALR:   begin pcsel = 1'b1; regwren = 1'b1; immsel = 1'b1; rs2sel = 1'b1; wbsel = 2'd2; end
      OP_LUI:    begin regwren = 1'b1; immsel = 1'b1; rs2sel = 1'b1; alusel = ALU_PASS; end
      OP_AUIPC:  begin regwren = 1'b1; immsel = 1'b1; rs1sel = 1'b1; rs2sel = 1'b1; end
      default:   known = 1'b0;
    endcase
  end

  assign bus.pcsel_o   = pcsel;
  assign bus.immsel_o  = immsel;
  assign bus.regwren_o = regwren;
  assign bus.rs1sel_o  = rs1sel;
  assign bus.rs2sel_o  = rs2sel;
  assign bus.memren_o  = memren;
  assign bus.memwren_o = memwren;
  assign bus.wbsel_o   = wbsel;
  assign bus.alusel_o  = alusel;

  logic [DWIDTH-1:0] op1, op2, alu;

  assign op1 = rs1sel ? pc_q : bus.rs1data_i;
  assign op2 = rs2sel ? imm  : bus.rs2data_i;

  always_comb begin
    alu = '0;
    unique case (alusel)
      ALU_ADD:  alu = op1 + op2;
      ALU_SUB:  alu = op1 - op2;
      ALU_SLL:  alu = op1 << op2[4:0];
      ALU_SLT:  alu = {{(DWIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu = {{(DWIDTH-1){1'b0}}, op1 < op2};
      ALU_XOR:  alu = op1 ^ op2;
      ALU_SRL:  alu = op1 >> op2[4:0];
      ALU_SRA:  alu = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_OR:   alu = op1 | op2;
      ALU_AND:  alu = op1 & op2;
      ALU_PASS: alu = op2;
      default:  alu = '0;
    endcase
  end

  always_comb begin
    bus.res_o = '0;
    if (known) begin
      bus.res_o = (opcode == OP_JALR) ? {alu[DWIDTH-1:1], 1'b0} : alu;
    end
  end

  // Branch compare always uses the register operands, never the PC/immediate muxes.
  always_comb begin
    bus.brtaken_o = 1'b0;
    if (opcode == OP_BRANCH) begin
      unique case (funct3)
        3'b000:  bus.brtaken_o = (bus.rs1data_i == bus.rs2data_i);
        3'b001:  bus.brtaken_o = (bus.rs1data_i != bus.rs2data_i);
        3'b100:  bus.brtaken_o = ($signed(bus.rs1data_i) <  $signed(bus.rs2data_i));
        3'b101:  bus.brtaken_o = ($signed(bus.rs1data_i) >= $signed(bus.rs2data_i));
        3'b110:  bus.brtaken_o = (bus.rs1data_i <  bus.rs2data_i);
        3'b111:  bus.brtaken_o = (bus.rs1data_i >= bus.rs2data_i);
        default: bus.brtaken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// Bench for rv_decode_exec: directed cases plus random instructions against an instruction-level reference model.
module tb_rv_decode_exec;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rv_decode_exec_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  rv_decode_exec #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] imm;
    logic [31:0] res;
    logic        br;
    logic        pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren;
    logic [1:0]  wbsel;
    logic [3:0]  alusel;
  } exp_t;

  // Reference copy of the instruction/PC the DUT should be holding.
  logic [31:0] m_insn;
  logic [31:0] m_pc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, x;
    logic [4:0]  sh;
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '{default: '0};
    case (i[6:0])
      7'h33, 7'h13: begin
        e.regwren = 1'b1;
        if (i[6:0] == 7'h13) begin
          e.imm = imm_i; e.immsel = 1'b1; e.rs2sel = 1'b1; x = imm_i;
        end else begin
          x = b;
        end
        sh = x[4:0];
        case (i[14:12])
          3'd0: if (i[6:0] == 7'h33 && i[30]) begin e.alusel = 4'd1; e.res = a - x; end
                else begin e.alusel = 4'd0; e.res = a + x; end
          3'd1: begin e.alusel = 4'd2; e.res = a << sh; end
          3'd2: begin e.alusel = 4'd3; e.res = ($signed(a) < $signed(x)) ? 32'd1 : 32'd0; end
          3'd3: begin e.alusel = 4'd4; e.res = (a < x) ? 32'd1 : 32'd0; end
          3'd4: begin e.alusel = 4'd5; e.res = a ^ x; end
          3'd5: if (i[30]) begin e.alusel = 4'd7; e.res = 32'($signed(a) >>> sh); end
                else begin e.alusel = 4'd6; e.res = a >> sh; end
          3'd6: begin e.alusel = 4'd8; e.res = a | x; end
          default: begin e.alusel = 4'd9; e.res = a & x; end
        endcase
      end
      7'h03: begin
        e.imm = imm_i; e.regwren = 1'b1; e.memren = 1'b1; e.immsel = 1'b1; e.rs2sel = 1'b1;
        e.wbsel = 2'd1; e.res = a + imm_i;
      end
      7'h23: begin
        e.imm = imm_s; e.memwren = 1'b1; e.immsel = 1'b1; e.rs2sel = 1'b1; e.res = a + imm_s;
      end
      7'h63: begin
        e.imm = imm_b; e.pcsel = 1'b1; e.immsel = 1'b1; e.rs1sel = 1'b1; e.rs2sel = 1'b1;
        e.res = pc + imm_b;
        case (i[14:12])
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = ($signed(a) < $signed(b));
          3'd5: e.br = !($signed(a) < $signed(b));
          3'd6: e.br = (a < b);
          3'd7: e.br = !(a < b);
          default: e.br = 1'b0;
        endcase
      end
      7'h6f: begin
        e.imm = imm_j; e.pcsel = 1'b1; e.regwren = 1'b1; e.immsel = 1'b1; e.rs1sel = 1'b1;
        e.rs2sel = 1'b1; e.wbsel = 2'd2; e.res = pc + imm_j;
      end
      7'h67: begin
        e.imm = imm_i; e.pcsel = 1'b1; e.regwren = 1'b1; e.immsel = 1'b1; e.rs2sel = 1'b1;
        e.wbsel = 2'd2; e.res = (a + imm_i) & 32'hFFFF_FFFE;
      end
      7'h37: begin
        e.imm = imm_u; e.regwren = 1'b1; e.immsel = 1'b1; e.rs2sel = 1'b1; e.alusel = 4'd10;
        e.res = imm_u;
      end
      7'h17: begin
        e.imm = imm_u; e.regwren = 1'b1; e.immsel = 1'b1; e.rs1sel = 1'b1; e.rs2sel = 1'b1;
        e.res = pc + imm_u;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_all(input string tag);
    exp_t e;
    e = model(m_insn, m_pc, bus.rs1data_i, bus.rs2data_i);
    chk_eq({tag, ".pc"},      bus.pc_o, m_pc);
    chk_eq({tag, ".insn"},    bus.insn_o, m_insn);
    chk_eq({tag, ".opcode"},  32'(bus.opcode_o), 32'(m_insn[6:0]));
    chk_eq({tag, ".rd"},      32'(bus.rd_o), 32'(m_insn[11:7]));
    chk_eq({tag, ".funct3"},  32'(bus.funct3_o), 32'(m_insn[14:12]));
    chk_eq({tag, ".rs1"},     32'(bus.rs1_o), 32'(m_insn[19:15]));
    chk_eq({tag, ".rs2"},     32'(bus.rs2_o), 32'(m_insn[24:20]));
    chk_eq({tag, ".funct7"},  32'(bus.funct7_o), 32'(m_insn[31:25]));
    chk_eq({tag, ".shamt"},   32'(bus.shamt_o), 32'(m_insn[24:20]));
    chk_eq({tag, ".imm"},     bus.imm_o, e.imm);
    chk_eq({tag, ".res"},     bus.res_o, e.res);
    chk_eq({tag, ".brtaken"}, 32'(bus.brtaken_o), 32'(e.br));
    chk_eq({tag, ".ctrl"},
           32'({bus.pcsel_o, bus.immsel_o, bus.regwren_o, bus.rs1sel_o, bus.rs2sel_o,
                bus.memren_o, bus.memwren_o}),
           32'({e.pcsel, e.immsel, e.regwren, e.rs1sel, e.rs2sel, e.memren, e.memwren}));
    chk_eq({tag, ".wbsel"},   32'(bus.wbsel_o), 32'(e.wbsel));
    chk_eq({tag, ".alusel"},  32'(bus.alusel_o), 32'(e.alusel));
  endtask

  // Present an instruction, clock it in, then apply register operands and check everything.
  task automatic step(input string tag, input logic r, input logic [31:0] insn,
                      input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    rst        = r;
    bus.insn_i = insn;
    bus.pc_i   = pc;
    @(posedge clk);
    if (r) begin m_insn = '0; m_pc = '0; end
    else   begin m_insn = insn; m_pc = pc; end
    #1;
    bus.rs1data_i = a;
    bus.rs2data_i = b;
    #1;
    check_all(tag);
  endtask

  logic [6:0] ops [12];

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f, 7'h7f};
    rst = 1'b1;
    bus.insn_i = '0; bus.pc_i = '0; bus.rs1data_i = '0; bus.rs2data_i = '0;
    m_insn = '0; m_pc = '0;

    step("reset", 1'b1, 32'h0050_0093, 32'h0100_0000, 32'h1234_5678, 32'h9abc_def0);
    chk_eq("reset.res0", bus.res_o, 32'h0);
    chk_eq("reset.ctrl0", 32'({bus.pcsel_o, bus.regwren_o, bus.memwren_o, bus.rs2sel_o}), 32'h0);

    step("addi", 1'b0, 32'h0050_0093, 32'h0100_0000, 32'h0, 32'h0);
    chk_eq("addi.res5", bus.res_o, 32'h5);
    chk_eq("addi.rd1", 32'(bus.rd_o), 32'h1);
    step("sub", 1'b0, 32'h4020_8033, 32'h0100_0004, 32'd7, 32'd9);
    chk_eq("sub.val", bus.res_o, 32'hFFFF_FFFE);
    chk_eq("sub.alusel", 32'(bus.alusel_o), 32'd1);
    step("sra", 1'b0, 32'h4020_D0B3, 32'h0100_0008, 32'h8000_0000, 32'd4);
    chk_eq("sra.val", bus.res_o, 32'hF800_0000);
    step("beq", 1'b0, 32'h0020_8463, 32'h0100_0010, 32'd3, 32'd3);
    chk_eq("beq.taken", 32'(bus.brtaken_o), 32'd1);
    chk_eq("beq.target", bus.res_o, 32'h0100_0018);
    step("bltu", 1'b0, 32'h0020_6463, 32'h0100_0010, 32'd5, 32'd3);
    chk_eq("bltu.nottaken", 32'(bus.brtaken_o), 32'd0);
    step("jal", 1'b0, 32'h0080_00EF, 32'h0100_0000, 32'h0, 32'h0);
    chk_eq("jal.target", bus.res_o, 32'h0100_0008);
    chk_eq("jal.wbsel", 32'(bus.wbsel_o), 32'd2);
    step("jalr", 1'b0, 32'h0000_8067, 32'h0100_0000, 32'h0100_0021, 32'h0);
    chk_eq("jalr.target", bus.res_o, 32'h0100_0020);
    step("lui", 1'b0, 32'h1234_50B7, 32'h0100_0000, 32'h5555_5555, 32'h0);
    chk_eq("lui.val", bus.res_o, 32'h1234_5000);
    step("auipc", 1'b0, 32'h0000_1097, 32'h0100_0004, 32'h0, 32'h0);
    chk_eq("auipc.val", bus.res_o, 32'h0100_1004);
    step("sw", 1'b0, 32'h0011_2223, 32'h0100_0008, 32'h100, 32'h7);
    chk_eq("sw.memwren", 32'(bus.memwren_o), 32'd1);
    chk_eq("sw.imm", bus.imm_o, 32'd4);
    step("ecall", 1'b0, 32'h0000_0073, 32'h0100_000C, 32'hFFFF_FFFF, 32'h1);
    chk_eq("ecall.res", bus.res_o, 32'h0);
    step("midrst", 1'b1, 32'h0080_00EF, 32'h0100_0000, 32'h1, 32'h2);

    for (int n = 0; n < 500; n++) begin
      logic [31:0] insn, a, b;
      insn = $urandom;
      insn[6:0] = ops[$urandom_range(0, 11)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = {27'b0, b[4:0]};
      step("rand", ($urandom_range(0, 19) == 0), insn, $urandom, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_decode_exec.md
# rv_decode_exec

Single-cycle RV32I decode/control/execute block for the PD-series core. It registers the fetched instruction and PC, then combinationally:
- splits the instruction into fields;
- generates the immediate and datapath control signals;
- computes the ALU result and branch decision from register-file operands.

It sits between fetch/instruction memory and the register file, data memory and writeback.

## Interface
- AWIDTH, 32, address/PC width
- DWIDTH, 32, data width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- insn_i  in  32  fetched instruction
- pc_i  in  AWIDTH  PC of insn_i
- rs1data_i / rs2data_i  in  DWIDTH  register-file read data for rs1_o / rs2_o
- pc_o  out  AWIDTH  registered PC
- insn_o  out  32  registered instruction
- opcode_o 7, rd_o 5, funct3_o 3, rs1_o 5, rs2_o 5, funct7_o 7, shamt_o 5  out  raw fields of insn_o
- imm_o  out  32  sign-extended immediate
- pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o  out  1  control
- wbsel_o  out  2  0=ALU, 1=memory, 2=PC+4
- alusel_o  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS-B
- res_o  out  DWIDTH  ALU result
- brtaken_o  out  1  conditional branch taken

## Operation
**Field extraction**
- Fields are always extracted raw, regardless of format: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], shamt[24:20].

**Immediate (imm_o)**
- I-format for 0010011, 0000011, 1100111.
- S-format for 0100011.
- B-format for 1100011.
- U-format ({insn[31:12],12'b0}) for 0110111, 0010111.
- J-format for 1101111.
- All other opcodes: 0.

**Control per opcode** (signals not listed are 0)
- R 0110011: regwren; alusel from funct3, with funct7[5] selecting SUB/SRA.
- OP-IMM 0010011: regwren, immsel, rs2sel; funct7[5] selects SRAI only for funct3=101.
- LOAD: regwren, memren, immsel, rs2sel, wbsel=1, ADD.
- STORE: memwren, immsel, rs2sel, ADD.
- BRANCH: pcsel, immsel, rs1sel, rs2sel, ADD.
- JAL: pcsel, regwren, immsel, rs1sel, rs2sel, wbsel=2, ADD.
- JALR: pcsel, regwren, immsel, rs2sel, wbsel=2, ADD.
- LUI: regwren, immsel, rs2sel, PASS-B.
- AUIPC: regwren, immsel, rs1sel, rs2sel, ADD.
- Any other opcode (incl. SYSTEM): all control 0, alusel=0.

**ALU**
- op1 = rs1sel ? pc_o : rs1data_i; op2 = rs2sel ? imm_o : rs2data_i.
- Shifts use op2[4:0].
- SLT is signed; SLTU is unsigned.
- JALR result = (op1+op2) & ~1.
- Unknown opcode: res_o=0.

**Branch (brtaken_o)**, only for opcode 1100011, comparing rs1data_i vs rs2data_i:
- funct3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
- funct3 010/011: 0.
- Jumps and non-branches: brtaken_o=0.

**Arithmetic**
- All arithmetic is modulo 2^32; overflow is ignored.

## Timing
- Rising clk: pc_o<=pc_i, insn_o<=insn_i; rst has priority.
- Reset: pc_o=0, insn_o=0. Consequently every field, imm_o, control output, res_o and brtaken_o reads 0.
- All other outputs are combinational from the registered state and rs*data_i, with zero added latency.
- One instruction is accepted per cycle; there is no stall or handshake.
- rst asserted mid-stream discards the held instruction at that edge.
- Simultaneous rst and new input: reset wins.

## Test plan
- Reset: rst=1 for one edge with insn_i=0x00500093 → pc_o=0, insn_o=0, all controls 0, res_o=0.
- ADDI: insn 0x00500093 (addi x1,x0,5), pc_i=0x01000000, rs1data=0 → next cycle rd_o=1, imm_o=5, regwren=1, rs2sel=1, res_o=5.
- SUB/SRA: insn 0x40208033 (sub x0,x1,x2) with rs1=7, rs2=9 → res_o=0xFFFFFFFE, alusel=1. Insn 0x4020D0B3 (sra) with rs1=0x80000000, rs2=4 → 0xF8000000.
- Branch: BEQ 0x00208463, pc=0x01000010, rs1=rs2=3 → brtaken=1, imm=8, res_o=0x01000018. Same operands under BLTU with rs1=5, rs2=3 → brtaken=0.
- JAL 0x008000EF at pc 0x01000000 → pcsel=1, wbsel=2, res_o=0x01000008, brtaken=0. JALR 0x00008067 with rs1=0x01000021 → res_o=0x01000020.
- LUI 0x123450B7 → res_o=0x12345000. AUIPC 0x00001097 at pc 0x01000004 → 0x01001004. SW 0x00112223 → memwren=1, imm=4. ECALL 0x00000073 → all controls 0.
